// File: rtl/sd_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_arbiter
// Brief    : Round-robin arbiter that gives the SD command host to software or
//            the data master. It has a done-timeout and a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module sd_cmd_arbiter #(
  parameter logic [15:0] TO_CYCLES = 16'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw_req,
  input  logic [31:0] sw_arg,
  input  logic [15:0] sw_set,
  output logic        sw_ack,
  input  logic        dm_req,
  input  logic [31:0] dm_arg,
  input  logic [15:0] dm_set,
  output logic        dm_ack,
  output logic        cmd_we,
  output logic [31:0] cmd_arg,
  output logic [15:0] cmd_set,
  input  logic        cmd_busy,
  input  logic        cmd_done,
  output logic        owner,
  output logic        cmd_err,
  input  logic        err_clr
);

  localparam logic [4:0]  c_ST_IDLE  = 5'b00001;
  localparam logic [4:0]  c_ST_ISSUE = 5'b00010;
  localparam logic [4:0]  c_ST_WAIT  = 5'b00100;
  localparam logic [4:0]  c_ST_ACK   = 5'b01000;
  localparam logic [4:0]  c_ST_REL   = 5'b10000;
  localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;

  logic [4:0]  r_state;
  logic [4:0]  w_next_state;
  logic [31:0] r_cmd_arg;
  logic [15:0] r_cmd_set;
  logic        r_owner;
  logic        r_cmd_err;
  logic [15:0] r_wait_cnt;

  logic        w_grant;
  logic        w_win_dm;
  logic        w_done_hit;
  logic        w_timeout;
  logic        w_owner_req;

  // r_owner also serves as the last-grant memory for the round-robin tie break.
  assign w_win_dm    = (sw_req && dm_req) ? ~r_owner : dm_req;
  assign w_grant     = (r_state == c_ST_IDLE) && (sw_req || dm_req) && !cmd_busy;
  assign w_done_hit  = (r_state == c_ST_WAIT) && cmd_done;
  assign w_timeout   = (r_state == c_ST_WAIT) && !cmd_done && (r_wait_cnt == TO_CYCLES);
  assign w_owner_req = r_owner ? dm_req : sw_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_grant) w_next_state = c_ST_ISSUE;
      c_ST_ISSUE: w_next_state = c_ST_WAIT;
      c_ST_WAIT:  if (w_done_hit || w_timeout) w_next_state = c_ST_ACK;
      c_ST_ACK:   w_next_state = c_ST_REL;
      c_ST_REL:   if (!w_owner_req) w_next_state = c_ST_IDLE;
      default:    w_next_state = c_ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_we = 1'b0;
    sw_ack = 1'b0;
    dm_ack = 1'b0;
    case (r_state)
      c_ST_ISSUE: cmd_we = 1'b1;
      c_ST_ACK: begin
        sw_ack = ~r_owner;
        dm_ack = r_owner;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_arg  <= 32'd0;
      r_cmd_set  <= 16'd0;
      r_owner    <= 1'b1;
      r_wait_cnt <= 16'd0;
      r_cmd_err  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner   <= w_win_dm;
        r_cmd_arg <= w_win_dm ? dm_arg : sw_arg;
        r_cmd_set <= w_win_dm ? dm_set : sw_set;
      end

      if (r_state == c_ST_ISSUE) begin
        r_wait_cnt <= 16'd0;
      end else if ((r_state == c_ST_WAIT) && (r_wait_cnt != c_CNT_MAX)) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end

      // A timeout in the same cycle as err_clr leaves the flag set.
      if (w_timeout) begin
        r_cmd_err <= 1'b1;
      end else if (err_clr) begin
        r_cmd_err <= 1'b0;
      end
    end
  end

  assign cmd_arg = r_cmd_arg;
  assign cmd_set = r_cmd_set;
  assign owner   = r_owner;
  assign cmd_err = r_cmd_err;

  a_state_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(r_state));
  a_ack_excl:     assert property (@(posedge clk) disable iff (rst) !(sw_ack && dm_ack));

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cmd_arbiter
// Brief    : Self-checking bench for sd_cmd_arbiter. It checks every cycle
//            against a transaction-level model and adds directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_arbiter;

  localparam int TB_TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sw_req, dm_req, cmd_busy, cmd_done, err_clr;
  logic [31:0] sw_arg, dm_arg;
  logic [15:0] sw_set, dm_set;
  logic        sw_ack, dm_ack, cmd_we, owner, cmd_err;
  logic [31:0] cmd_arg;
  logic [15:0] cmd_set;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  sd_cmd_arbiter #(.TO_CYCLES(16'd8)) dut (
    .clk(clk), .rst(rst),
    .sw_req(sw_req), .sw_arg(sw_arg), .sw_set(sw_set), .sw_ack(sw_ack),
    .dm_req(dm_req), .dm_arg(dm_arg), .dm_set(dm_set), .dm_ack(dm_ack),
    .cmd_we(cmd_we), .cmd_arg(cmd_arg), .cmd_set(cmd_set),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done),
    .owner(owner), .cmd_err(cmd_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Transaction model: one record per grant, with phases located by edge timestamps.
  int          m_cyc = 0;
  bit          m_active = 1'b0;
  logic        m_owner = 1'b1;
  logic [31:0] m_arg = 32'd0;
  logic [15:0] m_set = 16'd0;
  logic        m_err = 1'b0;
  int          m_grant_edge = -1;
  int          m_ack_edge = -1;
  int          m_waited = 0;

  logic m_winner_dm, m_issue_cyc, m_waiting, m_acking, m_releasing, m_timeout_now;
  assign m_winner_dm   = (sw_req && dm_req) ? !m_owner : dm_req;
  assign m_issue_cyc   = m_active && (m_cyc == m_grant_edge);
  assign m_waiting     = m_active && (m_ack_edge < 0) && (m_cyc > m_grant_edge);
  assign m_acking      = m_active && (m_ack_edge >= 0) && (m_cyc == m_ack_edge);
  assign m_releasing   = m_active && (m_ack_edge >= 0) && (m_cyc > m_ack_edge);
  assign m_timeout_now = m_waiting && !cmd_done && (m_waited == TB_TO);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active     <= 1'b0;
      m_owner      <= 1'b1;
      m_arg        <= 32'd0;
      m_set        <= 16'd0;
      m_err        <= 1'b0;
      m_grant_edge <= -1;
      m_ack_edge   <= -1;
      m_waited     <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (!m_active) begin
        if ((sw_req || dm_req) && !cmd_busy) begin
          m_active     <= 1'b1;
          m_owner      <= m_winner_dm;
          m_arg        <= m_winner_dm ? dm_arg : sw_arg;
          m_set        <= m_winner_dm ? dm_set : sw_set;
          m_grant_edge <= m_cyc + 1;
          m_ack_edge   <= -1;
          m_waited     <= 0;
        end
      end else if (m_waiting) begin
        if (cmd_done || m_timeout_now) m_ack_edge <= m_cyc + 1;
        else m_waited <= m_waited + 1;
      end else if (m_releasing) begin
        if (!(m_owner ? dm_req : sw_req)) m_active <= 1'b0;
      end
      if (m_timeout_now) m_err <= 1'b1;
      else if (err_clr) m_err <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cmd_we",  32'(cmd_we),  32'(m_issue_cyc));
      chk("sw_ack",  32'(sw_ack),  32'(m_acking && !m_owner));
      chk("dm_ack",  32'(dm_ack),  32'(m_acking && m_owner));
      chk("cmd_arg", cmd_arg,      m_arg);
      chk("cmd_set", 32'(cmd_set), 32'(m_set));
      chk("owner",   32'(owner),   32'(m_owner));
      chk("cmd_err", 32'(cmd_err), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_we(input int max_c, output int lat);
    lat = 0;
    while (lat < max_c) begin
      @(negedge clk);
      lat++;
      if (cmd_we === 1'b1) break;
    end
    tests++;
    if (cmd_we !== 1'b1) begin
      fails++;
      $display("FAIL wait_we: got no cmd_we within %0d cycles, required a strobe", max_c);
    end
  endtask

  // Pulse cmd_done n edges after the issue cycle, then stop at the negedge where the ack should show.
  task automatic done_after(input int n);
    repeat (n) @(posedge clk);
    #1 cmd_done = 1'b1;
    @(posedge clk);
    #1 cmd_done = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int cnt;
    sw_req = 0; dm_req = 0; sw_arg = 0; sw_set = 0; dm_arg = 0; dm_set = 0;
    cmd_busy = 0; cmd_done = 0; err_clr = 0;
    #1 rst = 1'b1;
    #1 chk_on = 1'b1;
    @(negedge clk);
    chk("rst_owner", 32'(owner), 32'd1);
    chk("rst_err", 32'(cmd_err), 32'd0);
    chk("rst_arg", cmd_arg, 32'd0);

    // Single software command.
    step(); rst = 0; sw_arg = 32'h12345678; sw_set = 16'h111A; sw_req = 1;
    wait_we(6, lat);
    chk("s1_latency", lat, 32'd2);
    chk("s1_arg", cmd_arg, 32'h12345678);
    chk("s1_set", 32'(cmd_set), 32'h111A);
    chk("s1_owner", 32'(owner), 32'd0);
    sw_arg = 32'hDEADBEEF; sw_set = 16'hBEEF;
    done_after(5);
    chk("s1_sw_ack", 32'(sw_ack), 32'd1);
    chk("s1_dm_ack", 32'(dm_ack), 32'd0);
    chk("s1_arg_held", cmd_arg, 32'h12345678);
    step(); sw_req = 0;
    repeat (3) step();

    // Both requesters from reset, then round robin.
    step(); rst = 1; sw_req = 1; dm_req = 1;
    sw_arg = 32'hA5A50001; sw_set = 16'h0101; dm_arg = 32'h5A5A0002; dm_set = 16'h0202;
    step(); rst = 0;
    wait_we(6, lat);
    chk("s2_first_owner", 32'(owner), 32'd0);
    chk("s2_first_arg", cmd_arg, 32'hA5A50001);
    done_after(2);
    chk("s2_sw_ack", 32'(sw_ack), 32'd1);
    step(); sw_req = 0;
    wait_we(8, lat);
    chk("s2_second_owner", 32'(owner), 32'd1);
    chk("s2_second_arg", cmd_arg, 32'h5A5A0002);
    chk("s2_second_set", 32'(cmd_set), 32'h0202);
    done_after(3);
    chk("s2_dm_ack", 32'(dm_ack), 32'd1);
    step(); dm_req = 0;
    step(); sw_req = 1; dm_req = 1;
    wait_we(8, lat);
    chk("s2_rr_owner", 32'(owner), 32'd0);
    sw_req = 0;
    done_after(2);
    chk("s2_early_drop_ack", 32'(sw_ack), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("s2_release_one_cycle_we", 32'(cmd_we), 32'd1);
    chk("s2_release_one_cycle_owner", 32'(owner), 32'd1);
    dm_req = 0;
    done_after(1);
    chk("s2_dm_ack2", 32'(dm_ack), 32'd1);
    repeat (3) step();

    // Timeout without cmd_done, then clear.
    step(); dm_req = 1; dm_arg = 32'hC0FFEE00; dm_set = 16'h0033;
    wait_we(6, lat);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("s3_err_before", 32'(cmd_err), 32'd0);
    chk("s3_ack_before", 32'(dm_ack), 32'd0);
    @(negedge clk);
    chk("s3_timeout_ack", 32'(dm_ack), 32'd1);
    chk("s3_err_set", 32'(cmd_err), 32'd1);
    step(); dm_req = 0;
    @(negedge clk);
    chk("s3_err_sticky", 32'(cmd_err), 32'd1);
    step(); err_clr = 1;
    step(); err_clr = 0;
    @(negedge clk);
    chk("s3_err_clr", 32'(cmd_err), 32'd0);

    // cmd_done arriving on the timeout cycle.
    step(); sw_req = 1; sw_arg = 32'h0000BEEF;
    wait_we(6, lat);
    done_after(9);
    chk("s4_ack", 32'(sw_ack), 32'd1);
    chk("s4_err_clear", 32'(cmd_err), 32'd0);
    step(); sw_req = 0;
    repeat (2) step();

    // Timeout with err_clr held: set wins, then the clear takes effect.
    step(); dm_req = 1; err_clr = 1;
    wait_we(6, lat);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("s4b_ack", 32'(dm_ack), 32'd1);
    chk("s4b_set_wins", 32'(cmd_err), 32'd1);
    @(negedge clk);
    chk("s4b_cleared", 32'(cmd_err), 32'd0);
    err_clr = 0; dm_req = 0;
    repeat (3) step();

    // Host busy blocks the grant.
    step(); cmd_busy = 1; sw_req = 1; sw_arg = 32'h0BADF00D;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      cnt += int'(cmd_we);
    end
    chk("s5_no_we_busy", cnt, 32'd0);
    step(); cmd_busy = 0;
    wait_we(6, lat);
    chk("s5_latency", lat, 32'd2);
    chk("s5_owner", 32'(owner), 32'd0);
    done_after(1);
    chk("s5_ack", 32'(sw_ack), 32'd1);
    step(); sw_req = 0;
    repeat (2) step();

    // Reset mid-wait, no ack, then normal service.
    step(); sw_req = 1; sw_arg = 32'h77770001; sw_set = 16'h0777;
    wait_we(6, lat);
    repeat (3) step();
    rst = 1; sw_req = 0;
    #1;
    chk("s6_rst_owner", 32'(owner), 32'd1);
    chk("s6_rst_arg", cmd_arg, 32'd0);
    chk("s6_rst_set", 32'(cmd_set), 32'd0);
    chk("s6_rst_we", 32'(cmd_we), 32'd0);
    @(negedge clk);
    step(); rst = 0; cmd_done = 1;
    step(); cmd_done = 0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      cnt += int'(sw_ack) + int'(dm_ack);
    end
    chk("s6_no_ack", cnt, 32'd0);
    step(); dm_req = 1; dm_arg = 32'h88880002;
    wait_we(6, lat);
    chk("s6_latency", lat, 32'd2);
    chk("s6_owner", 32'(owner), 32'd1);
    chk("s6_arg", cmd_arg, 32'h88880002);
    done_after(2);
    chk("s6_ack", 32'(dm_ack), 32'd1);
    step(); dm_req = 0;
    repeat (3) step();

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
